// File: rtl/interval_sched.sv
// interval_sched: four requesters share one down-counter. A round-robin
// arbiter hands the counter to one requester at a time. The owner's interval
// runs for len cycles, or ends early on abort. A one-cycle done pulse to the
// owner closes the interval.
module interval_sched #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] len,
    input  logic               abort,
    output logic [3:0]         grant,
    output logic [3:0]         done,
    output logic               aborted,
    output logic               busy,
    output logic [WIDTH-1:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg,   state_next;
    logic [3:0]       grant_reg,   grant_next;
    logic [3:0]       done_reg,    done_next;
    logic             aborted_reg, aborted_next;
    logic             busy_reg,    busy_next;
    logic [WIDTH-1:0] count_reg,   count_next;
    logic [1:0]       last_reg,    last_next;
    logic [1:0]       owner_reg,   owner_next;

    // Per-requester length slices, and the candidates in search order.
    // Slot 0 is the requester after last; slot 3 is last itself.
    logic [WIDTH-1:0] len_arr  [4];
    logic [1:0]       cand_idx [4];
    logic [3:0]       cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign len_arr[gi]  = len[gi*WIDTH +: WIDTH];
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    logic       win_valid;
    logic [1:0] win_idx;
    logic [3:0] win_onehot;

    // Round-robin pick: the earliest slot in search order with a request wins.
    always_comb begin
        win_idx   = 2'd0;
        win_valid = |req;
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
        win_onehot = 4'b0001 << win_idx;
    end

    // Next-state and next-output logic. Every output is a register.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        done_next    = done_reg;
        aborted_next = aborted_reg;
        busy_next    = busy_reg;
        count_next   = count_reg;
        last_next    = last_reg;
        owner_next   = owner_reg;
        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    grant_next = win_onehot;
                    owner_next = win_idx;
                    count_next = len_arr[win_idx];
                    busy_next  = 1'b1;
                    if (len_arr[win_idx] == '0) begin
                        // A zero-length interval goes straight to completion.
                        state_next = DONE;
                        done_next  = win_onehot;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort freezes count and takes priority over normal expiry.
                    state_next   = DONE;
                    done_next    = grant_reg;
                    aborted_next = 1'b1;
                end else if (count_reg <= CNT_ONE) begin
                    // The counter stops at zero and never wraps.
                    state_next = DONE;
                    done_next  = grant_reg;
                    count_next = '0;
                end else begin
                    count_next = count_reg - CNT_ONE;
                end
            end
            DONE: begin
                state_next   = IDLE;
                last_next    = owner_reg;
                grant_next   = 4'b0000;
                done_next    = 4'b0000;
                aborted_next = 1'b0;
                busy_next    = 1'b0;
            end
            default: begin
                state_next   = IDLE;
                grant_next   = 4'b0000;
                done_next    = 4'b0000;
                aborted_next = 1'b0;
                busy_next    = 1'b0;
            end
        endcase
    end

    // State register. On clr, last is set to 3 so that requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            grant_reg   <= 4'b0000;
            done_reg    <= 4'b0000;
            aborted_reg <= 1'b0;
            busy_reg    <= 1'b0;
            count_reg   <= '0;
            last_reg    <= 2'd3;
            owner_reg   <= 2'd0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
            busy_reg    <= busy_next;
            count_reg   <= count_next;
            last_reg    <= last_next;
            owner_reg   <= owner_next;
        end
    end

    assign grant   = grant_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;
    assign busy    = busy_reg;
    assign count   = count_reg;

endmodule

// File: tb/tb_interval_sched.sv
// Testbench for interval_sched. Each cycle's expected outputs are pushed to a
// queue as the stimulus is driven. They are popped and compared after the edge.
module tb_interval_sched;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               clr;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] len;
    logic               abort;
    logic [3:0]         grant;
    logic [3:0]         done;
    logic               aborted;
    logic               busy;
    logic [WIDTH-1:0]   count;

    interval_sched #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .len     (len),
        .abort   (abort),
        .grant   (grant),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       g;
        logic [3:0]       d;
        logic             a;
        logic             b;
        logic [WIDTH-1:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_len(input int idx, input logic [WIDTH-1:0] v);
        len[idx*WIDTH +: WIDTH] = v;
    endtask

    // Queue the expected outputs for the next cycle, clock once, then compare.
    task automatic step(input logic [3:0] g, input logic [3:0] d, input logic a,
                        input logic b, input logic [WIDTH-1:0] c);
        exp_t e;
        e.g = g; e.d = d; e.a = a; e.b = b; e.c = c;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            $display("cyc %0d: grant=%b done=%b aborted=%b busy=%b count=%0d", cyc, grant, done, aborted, busy, count);
            check_val("grant",   32'(grant),   32'(e.g));
            check_val("done",    32'(done),    32'(e.d));
            check_val("aborted", 32'(aborted), 32'(e.a));
            check_val("busy",    32'(busy),    32'(e.b));
            check_val("count",   32'(count),   32'(e.c));
        end
    endtask

    initial begin
        clr = 1'b1; req = 4'b0; len = '0; abort = 1'b0;
        // Reset state
        step(4'b0000, 4'b0000, 0, 0, 0);
        clr = 1'b0;

        // Single request of length 3
        set_len(0, 3); req = 4'b0001;
        step(4'b0001, 4'b0000, 0, 1, 3);
        step(4'b0001, 4'b0000, 0, 1, 2);
        step(4'b0001, 4'b0000, 0, 1, 1);
        step(4'b0001, 4'b0001, 0, 1, 0);
        req = 4'b0000;
        step(4'b0000, 4'b0000, 0, 0, 0);

        // Round-robin with all requests held and all lengths 1; clr restores last=3
        clr = 1'b1;
        step(4'b0000, 4'b0000, 0, 0, 0);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) set_len(i, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            step(oh, 4'b0000, 0, 1, 1);
            step(oh, oh, 0, 1, 0);
            if (k == 4) req = 4'b0000;
            step(4'b0000, 4'b0000, 0, 0, 0);
        end

        // Zero-length interval goes directly to DONE
        set_len(2, 0); req = 4'b0100;
        step(4'b0100, 4'b0100, 0, 1, 0);
        req = 4'b0000;
        step(4'b0000, 4'b0000, 0, 0, 0);

        // Abort held in IDLE has no effect
        abort = 1'b1;
        step(4'b0000, 4'b0000, 0, 0, 0);
        abort = 1'b0;

        // Abort at count 7. The owner drops req and len changes mid-run; neither has any effect.
        set_len(1, 10); req = 4'b0010;
        step(4'b0010, 4'b0000, 0, 1, 10);
        req = 4'b0000; set_len(1, 2);
        step(4'b0010, 4'b0000, 0, 1, 9);
        step(4'b0010, 4'b0000, 0, 1, 8);
        step(4'b0010, 4'b0000, 0, 1, 7);
        abort = 1'b1;
        step(4'b0010, 4'b0010, 1, 1, 7);
        step(4'b0000, 4'b0000, 0, 0, 7);
        abort = 1'b0;

        // clr during RUN kills the interval with no done pulse
        set_len(3, 5); req = 4'b1000;
        step(4'b1000, 4'b0000, 0, 1, 5);
        step(4'b1000, 4'b0000, 0, 1, 4);
        step(4'b1000, 4'b0000, 0, 1, 3);
        clr = 1'b1;
        step(4'b0000, 4'b0000, 0, 0, 0);
        clr = 1'b0; set_len(0, 2); req = 4'b1001;
        step(4'b0001, 4'b0000, 0, 1, 2);
        step(4'b0001, 4'b0000, 0, 1, 1);
        step(4'b0001, 4'b0001, 0, 1, 0);
        req = 4'b1000;
        step(4'b0000, 4'b0000, 0, 0, 0);
        // Requester 3 is next; let it finish
        step(4'b1000, 4'b0000, 0, 1, 5);
        req = 4'b0000;
        for (int v = 4; v >= 1; v--) step(4'b1000, 4'b0000, 0, 1, WIDTH'(v));
        step(4'b1000, 4'b1000, 0, 1, 0);
        step(4'b0000, 4'b0000, 0, 0, 0);

        // Abort at count 1 takes priority over expiry
        set_len(2, 2); req = 4'b0100;
        step(4'b0100, 4'b0000, 0, 1, 2);
        step(4'b0100, 4'b0000, 0, 1, 1);
        abort = 1'b1;
        step(4'b0100, 4'b0100, 1, 1, 1);
        abort = 1'b0; req = 4'b0000;
        step(4'b0000, 4'b0000, 0, 0, 1);

        // A requester that still holds req after its done pulse is arbitrated again, at lowest priority
        set_len(1, 1); set_len(2, 1); req = 4'b0110;
        step(4'b0010, 4'b0000, 0, 1, 1);
        step(4'b0010, 4'b0010, 0, 1, 0);
        step(4'b0000, 4'b0000, 0, 0, 0);
        req = 4'b0010;
        step(4'b0010, 4'b0000, 0, 1, 1);
        step(4'b0010, 4'b0010, 0, 1, 0);
        req = 4'b0000;
        step(4'b0000, 4'b0000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
